bomba_piscina_multi: RTL



---
 rtl/bomba_piscina_multi.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bomba_piscina_multi.sv
// bomba_piscina_multi: NCH independent solar/grid pool-pump controllers with duty cycling,
// dark-time debt repayment and grid fallback, all advancing on a shared tick enable.
module bomba_piscina_multi #(
   parameter int NCH       = 2,
   parameter int ON_TICKS  = 1,
   parameter int OFF_TICKS = 1,
   parameter int MAX_DEBT  = 3
) (
   input  logic             clk_2,
   input  logic             reset_n,
   input  logic             tick,
   input  logic [NCH-1:0]   sol,
   output logic [NCH-1:0]   painel,
   output logic [NCH-1:0]   rede,
   output logic [3*NCH-1:0] st,
   output logic             rede_any
);
   localparam int DW   = $clog2(MAX_DEBT + 1);
   localparam int PMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;
   localparam logic [DW-1:0] DMAX   = DW'(MAX_DEBT);
   localparam logic [PW-1:0] ON_M1  = PW'(ON_TICKS - 1);
   localparam logic [PW-1:0] OFF_M1 = PW'(OFF_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SOL_ON  = 3'd1,
      SOL_OFF = 3'd2,
      DARK    = 3'd3,
      GRID    = 3'd4,
      PAYBACK = 3'd5
   } state_e;

   // Blocks the tick that shares its cycle with reset release.
   logic armed_q;
   logic adv;
   logic [NCH-1:0] rede_d;
   logic rede_any_q;

   always_ff @(posedge clk_2 or negedge reset_n) begin
      if (!reset_n) begin
         armed_q    <= 1'b0;
         rede_any_q <= 1'b0;
      end else begin
         armed_q    <= 1'b1;
         rede_any_q <= |rede_d;
      end
   end

   assign adv      = tick & armed_q;
   assign rede_any = rede_any_q;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      state_e state_q, state_d;
      logic [DW-1:0] debt_q, debt_d;
      logic [PW-1:0] ph_q, ph_d;
      logic painel_q, rede_q;
      logic s;

      assign s = sol[c];

      always_comb begin
         state_d = state_q;
         debt_d  = debt_q;
         ph_d    = ph_q;
         if (adv) begin
            case (state_q)
               IDLE: begin
                  if (s) begin
                     state_d = SOL_ON;
                     ph_d    = ON_M1;
                  end else begin
                     state_d = DARK;
                     debt_d  = DW'(1);
                  end
               end
               SOL_ON, SOL_OFF: begin
                  if (!s) begin
                     state_d = DARK;
                     debt_d  = DW'(1);
                  end else if (ph_q == '0) begin
                     state_d = (state_q == SOL_ON) ? SOL_OFF : SOL_ON;
                     ph_d    = (state_q == SOL_ON) ? OFF_M1 : ON_M1;
                  end else begin
                     ph_d = ph_q - PW'(1);
                  end
               end
               DARK: begin
                  if (s) begin
                     state_d = PAYBACK;
                     debt_d  = debt_q - DW'(1);
                  end else if (debt_q < DMAX) begin
                     debt_d = debt_q + DW'(1);
                  end else begin
                     state_d = GRID;
                  end
               end
               PAYBACK: begin
                  if (!s) begin
                     state_d = DARK;
                     debt_d  = (debt_q >= DMAX) ? DMAX : debt_q + DW'(1);
                  end else if (debt_q == '0) begin
                     state_d = SOL_OFF;
                     ph_d    = OFF_M1;
                  end else begin
                     debt_d = debt_q - DW'(1);
                  end
               end
               GRID: begin
                  if (s) begin
                     state_d = SOL_ON;
                     debt_d  = '0;
                     ph_d    = ON_M1;
                  end
               end
               default: begin
                  state_d = IDLE;
                  debt_d  = '0;
                  ph_d    = '0;
               end
            endcase
         end
      end

      always_ff @(posedge clk_2 or negedge reset_n) begin
         if (!reset_n) begin
            state_q  <= IDLE;
            debt_q   <= '0;
            ph_q     <= '0;
            painel_q <= 1'b0;
            rede_q   <= 1'b0;
         end else begin
            state_q  <= state_d;
            debt_q   <= debt_d;
            ph_q     <= ph_d;
            painel_q <= (state_d == SOL_ON) || (state_d == PAYBACK);
            rede_q   <= (state_d == GRID);
         end
      end

      assign rede_d[c]     = (state_d == GRID);
      assign painel[c]     = painel_q;
      assign rede[c]       = rede_q;
      assign st[3*c +: 3]  = state_q;
   end
endmodule
